branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch and halt sequencer for the 16-bit WISC pipeline, sitting between decode and the IF/ID/EX pipeline registers. It owns the architectural flag register (Z, V, N), detects flag and register hazards for a branch in ID, stalls until the branch can resolve, then issues the PC redirect and IF/ID flush in the resolving cycle. It also latches HLT and keeps saturating taken-branch and stall-cycle counters.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction, not a bubble
- id_instr  in  16  instruction in ID; [15:12] opcode, [11:9] condition, [7:4] rs for BR
- ex_valid  in  1  EX holds a real instruction
- ex_flag_we  in  3  EX flag write enables {Z,V,N}
- ex_flags  in  3  ALU flag results {Z,V,N} from EX
- ex_wr_en  in  1  EX instruction writes a register
- ex_rd  in  4  EX destination register
- mem_wr_en  in  1  MEM instruction writes a register
- mem_rd  in  4  MEM destination register
- flags  out  3  architectural {Z,V,N}
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- redirect  out  1  load PC from branch target this cycle
- flush_ifid  out  1  squash instruction entering ID next cycle
- halted  out  1  HLT reached; fetch frozen
- br_taken_cnt  out  CNT_W  taken branches, saturating
- stall_cnt  out  CNT_W  stall cycles, saturating

## Operation
- Branch = opcode 4'b1100 (B) or 4'b1101 (BR); HLT = 4'b1111. A branch is considered only when id_valid=1.
- Condition codes: 000 NE (!Z), 001 EQ (Z), 010 GT (!Z & !N), 011 LT (N), 100 GE (Z | (!Z & !N)), 101 LE (N | Z), 110 OV (V), 111 unconditional.
- Flag register: each bit updates from ex_flags when ex_valid and its ex_flag_we bit are set; other bits hold.
- Flag hazard: a conditional branch (cond ≠ 111) in ID while ex_valid and ex_flag_we≠0.
- Register hazard: BR in ID while (ex_valid & ex_wr_en & ex_rd==rs) or (mem_wr_en & mem_rd==rs). B never has a register hazard.
- FSM states: RUN, STALL, HALT.
  - RUN: branch with hazard → stall=1, go STALL. Branch without hazard → resolve now; if taken, redirect=flush_ifid=1. HLT → go HALT.
  - STALL: stall=1 while any hazard remains. When clear, resolve exactly as in RUN and return to RUN.
  - HALT: stall=1 permanently; redirect=flush_ifid=0; halted=1. Exit only via rst.
- HLT in ID while flush_ifid=1 in the same cycle is impossible by construction: only one ID slot exists, and a branch in ID excludes HLT.
- Counters: br_taken_cnt increments on each redirect; stall_cnt increments on each stall cycle in STALL or RUN. Both hold at all-ones and do not count in HALT.

## Timing
- Branch resolution is combinational in ID: zero added latency with no hazard, so redirect and flush_ifid are asserted in the same cycle as the branch in ID.
- Flag hazard costs exactly 1 stall cycle. The flag write and the resolution decision use the post-write value in the next cycle.
- BR hazard against EX costs 2 cycles; against MEM only, 1 cycle.
- Simultaneous flag write and branch in ID: the branch stalls and never uses stale flags.
- Reset: while rst=1, the next edge forces RUN, flags=000, and counters=0. Outputs stall, redirect, flush_ifid, and halted are 0 during and after reset until new input arrives. Reset mid-STALL or in HALT behaves identically.

## Structure
- wisc_pkg: opcode constants (OP_B, OP_BR, OP_HLT), condition code constants, FSM state enum, flag bit indices.
- Sub-module br_cond: combinational evaluator taking cond[2:0] and {Z,V,N} and producing taken. It is reusable by other branch users.
- branch_ctrl contains the FSM, flag register, hazard compare, and counters.

## Test plan
- Flags=100 (Z=1), EQ B in ID, EX without flag write → redirect=flush_ifid=1 same cycle, stall=0, br_taken_cnt=1.
- SUB in EX with ex_flag_we=111 and ex_flags=001, LT branch in ID → stall=1 for 1 cycle, then redirect=1 with flags=001, stall_cnt=1.
- BR rs=3 with ex_rd=3 write in EX, then moving to MEM → stall for 2 cycles, then resolve (unconditional → redirect=1).
- HLT in ID → halted=1 and stall=1 from that cycle on. Subsequent branches are ignored and counters are frozen. rst=1 → halted=0, state RUN.
- Assert rst during a STALL → after the edge, stall=0, flags=000, counters=0. Force 2^CNT_W+3 taken branches → br_taken_cnt saturates at all-ones.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, branch condition codes, flag bit
// positions and the branch-sequencer state encoding.
package wisc_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // Flag vector is packed {Z,V,N}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } br_state_t;

endpackage

// File: rtl/br_cond.sv
// Combinational branch-condition evaluator: decides taken from a 3-bit
// condition code and the {Z,V,N} flag vector.
module br_cond
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    unique case (cond)
      CC_NE:     taken = !z;
      CC_EQ:     taken = z;
      CC_GT:     taken = !z && !n;
      CC_LT:     taken = n;
      CC_GE:     taken = z || (!z && !n);
      CC_LE:     taken = n || z;
      CC_OV:     taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch and halt sequencer: owns the architectural flags, stalls a branch in
// ID until its flags/source register are final, then redirects and flushes.
module branch_ctrl
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [15:0]      id_instr,
  input  logic             ex_valid,
  input  logic [2:0]       ex_flag_we,
  input  logic [2:0]       ex_flags,
  input  logic             ex_wr_en,
  input  logic [3:0]       ex_rd,
  input  logic             mem_wr_en,
  input  logic [3:0]       mem_rd,
  output logic [2:0]       flags,
  output logic             stall,
  output logic             redirect,
  output logic             flush_ifid,
  output logic             halted,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  br_state_t  state_q, state_d;
  logic [2:0] flags_q;

  logic [3:0] opcode;
  logic [2:0] cond;
  logic [3:0] rs;
  logic       is_branch, is_br, is_hlt;
  logic       flag_haz, reg_haz, hazard;
  logic       taken;
  logic       stall_c, redirect_c, halted_c;

  // Immediate/offset bits are consumed by the PC adder, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{id_instr[8], id_instr[3:0]};

  assign opcode = id_instr[15:12];
  assign cond   = id_instr[11:9];
  assign rs     = id_instr[7:4];

  assign is_branch = id_valid && (opcode == OP_B || opcode == OP_BR);
  assign is_br     = id_valid && (opcode == OP_BR);
  assign is_hlt    = id_valid && (opcode == OP_HLT);

  // A flag write in EX lands at the next edge, so a conditional branch must
  // wait one cycle to see it rather than bypassing the ALU result.
  assign flag_haz = is_branch && (cond != CC_UNCOND) && ex_valid && (ex_flag_we != 3'b000);
  assign reg_haz  = is_br && ((ex_valid && ex_wr_en && (ex_rd == rs)) ||
                              (mem_wr_en && (mem_rd == rs)));
  assign hazard   = flag_haz || reg_haz;

  br_cond u_br_cond (
    .cond  (cond),
    .flags (flags_q),
    .taken (taken)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    stall_c    = 1'b0;
    redirect_c = 1'b0;
    halted_c   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (is_branch) begin
          if (hazard) begin
            stall_c = 1'b1;
            state_d = ST_STALL;
          end else begin
            redirect_c = taken;
          end
        end else if (is_hlt) begin
          stall_c  = 1'b1;
          halted_c = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_STALL: begin
        if (!is_branch) begin
          state_d = ST_RUN;
        end else if (hazard) begin
          stall_c = 1'b1;
        end else begin
          redirect_c = taken;
          state_d    = ST_RUN;
        end
      end
      ST_HALT: begin
        stall_c  = 1'b1;
        halted_c = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    // Control outputs stay quiet for the whole reset cycle.
    if (rst) begin
      stall_c    = 1'b0;
      redirect_c = 1'b0;
      halted_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= ST_RUN;
      flags_q      <= 3'b000;
      br_taken_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 3; i++) begin
        if (ex_valid && ex_flag_we[i]) flags_q[i] <= ex_flags[i];
      end
      if (redirect_c && (br_taken_cnt != '1)) br_taken_cnt <= br_taken_cnt + 1'b1;
      if (stall_c && (state_q != ST_HALT) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign flags      = flags_q;
  assign stall      = stall_c;
  assign redirect   = redirect_c;
  assign flush_ifid = redirect_c;
  assign halted     = halted_c;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: flag/register hazards, halt, reset and
// counter saturation, with hand-computed expectations.
module tb_branch_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [15:0]      id_instr;
  logic             ex_valid;
  logic [2:0]       ex_flag_we;
  logic [2:0]       ex_flags;
  logic             ex_wr_en;
  logic [3:0]       ex_rd;
  logic             mem_wr_en;
  logic [3:0]       mem_rd;
  logic [2:0]       flags;
  logic             stall;
  logic             redirect;
  logic             flush_ifid;
  logic             halted;
  logic [CNT_W-1:0] br_taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Instruction encodings used below.
  localparam logic [15:0] I_B_EQ     = 16'hC200;
  localparam logic [15:0] I_B_NE     = 16'hC000;
  localparam logic [15:0] I_B_LT     = 16'hC600;
  localparam logic [15:0] I_B_UNC    = 16'hCE00;
  localparam logic [15:0] I_B_UNC_R3 = 16'hCE30;
  localparam logic [15:0] I_BR_R3    = 16'hDE30;
  localparam logic [15:0] I_HLT      = 16'hF000;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .ex_valid     (ex_valid),
    .ex_flag_we   (ex_flag_we),
    .ex_flags     (ex_flags),
    .ex_wr_en     (ex_wr_en),
    .ex_rd        (ex_rd),
    .mem_wr_en    (mem_wr_en),
    .mem_rd       (mem_rd),
    .flags        (flags),
    .stall        (stall),
    .redirect     (redirect),
    .flush_ifid   (flush_ifid),
    .halted       (halted),
    .br_taken_cnt (br_taken_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then wait 1 time unit before driving new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid   = 1'b0;
    id_instr   = 16'h0000;
    ex_valid   = 1'b0;
    ex_flag_we = 3'b000;
    ex_flags   = 3'b000;
    ex_wr_en   = 1'b0;
    ex_rd      = 4'd0;
    mem_wr_en  = 1'b0;
    mem_rd     = 4'd0;
  endtask

  task automatic id_set(input logic [15:0] instr);
    id_valid = 1'b1;
    id_instr = instr;
  endtask

  task automatic check_ctl(input string tag, input logic s, input logic r, input logic h);
    #2;
    check({tag, "_stall"},    32'(stall),      32'(s));
    check({tag, "_redirect"}, 32'(redirect),   32'(r));
    check({tag, "_flush"},    32'(flush_ifid), 32'(r));
    check({tag, "_halted"},   32'(halted),     32'(h));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    // Reset: an unconditional branch in ID must not leak through.
    id_set(I_B_UNC);
    check_ctl("rst_gate", 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_brcnt", 32'(br_taken_cnt), 32'h0);
    check("rst_stcnt", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    idle_inputs();

    // Full then partial flag write: only V is cleared by the second one.
    ex_valid = 1'b1; ex_flag_we = 3'b111; ex_flags = 3'b110;
    tick();
    check("flags_full", 32'(flags), 32'b110);
    ex_flag_we = 3'b010; ex_flags = 3'b000;
    tick();
    check("flags_partial", 32'(flags), 32'b100);
    idle_inputs();

    // Z=1: EQ taken in the same cycle, NE not taken.
    id_set(I_B_EQ);
    check_ctl("eq_taken", 1'b0, 1'b1, 1'b0);
    tick();
    check("eq_brcnt", 32'(br_taken_cnt), 32'd1);
    id_set(I_B_NE);
    check_ctl("ne_not_taken", 1'b0, 1'b0, 1'b0);
    tick();
    check("ne_brcnt", 32'(br_taken_cnt), 32'd1);

    // Flag hazard: one stall cycle, then LT resolves on the new flags 001.
    ex_valid = 1'b1; ex_flag_we = 3'b111; ex_flags = 3'b001;
    id_set(I_B_LT);
    check_ctl("lt_hazard", 1'b1, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0; ex_flag_we = 3'b000;
    check_ctl("lt_resolve", 1'b0, 1'b1, 1'b0);
    check("lt_flags", 32'(flags), 32'b001);
    check("lt_stcnt", 32'(stall_cnt), 32'd1);
    tick();
    check("lt_brcnt", 32'(br_taken_cnt), 32'd2);

    // BR r3 against EX, then MEM: two stall cycles then redirect.
    ex_valid = 1'b1; ex_wr_en = 1'b1; ex_rd = 4'd3;
    id_set(I_BR_R3);
    check_ctl("br_ex_haz", 1'b1, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0; ex_wr_en = 1'b0; mem_wr_en = 1'b1; mem_rd = 4'd3;
    check_ctl("br_mem_haz", 1'b1, 1'b0, 1'b0);
    tick();
    mem_wr_en = 1'b0;
    check_ctl("br_resolve", 1'b0, 1'b1, 1'b0);
    tick();
    check("br_stcnt", 32'(stall_cnt), 32'd3);
    check("br_brcnt", 32'(br_taken_cnt), 32'd3);

    // Different destination: no hazard. B ignores the rs field entirely.
    ex_valid = 1'b1; ex_wr_en = 1'b1; ex_rd = 4'd5;
    check_ctl("br_no_haz", 1'b0, 1'b1, 1'b0);
    tick();
    ex_rd = 4'd3;
    id_set(I_B_UNC_R3);
    check_ctl("b_no_reghaz", 1'b0, 1'b1, 1'b0);
    tick();
    check("b_brcnt", 32'(br_taken_cnt), 32'd5);
    idle_inputs();

    // HLT: halted and stalled from that cycle; HLT cycle counts as a RUN stall.
    id_set(I_HLT);
    check_ctl("hlt_enter", 1'b1, 1'b0, 1'b1);
    tick();
    id_set(I_B_UNC);
    check_ctl("hlt_ignore_br", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    check_ctl("hlt_hold", 1'b1, 1'b0, 1'b1);
    check("hlt_brcnt", 32'(br_taken_cnt), 32'd5);
    check("hlt_stcnt", 32'(stall_cnt), 32'd4);

    // Reset out of HALT.
    rst = 1'b1;
    check_ctl("hlt_rst_during", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    idle_inputs();
    check_ctl("hlt_rst_after", 1'b0, 1'b0, 1'b0);
    check("hlt_rst_brcnt", 32'(br_taken_cnt), 32'd0);

    // Reset in the middle of a flag-hazard stall.
    ex_valid = 1'b1; ex_flag_we = 3'b111; ex_flags = 3'b100;
    id_set(I_B_LT);
    check_ctl("mid_stall", 1'b1, 1'b0, 1'b0);
    tick();
    check("mid_stall_cnt", 32'(stall_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_ctl("mid_rst_after", 1'b0, 1'b0, 1'b0);
    check("mid_rst_flags", 32'(flags), 32'h0);
    check("mid_rst_stcnt", 32'(stall_cnt), 32'd0);
    id_set(I_B_UNC);
    check_ctl("mid_rst_run", 1'b0, 1'b1, 1'b0);

    // Saturation: 2^CNT_W + 3 taken branches from a zero count.
    for (int i = 0; i < 65535; i++) tick();
    check("sat_reach", 32'(br_taken_cnt), 32'hFFFF);
    for (int i = 0; i < 4; i++) tick();
    check("sat_hold", 32'(br_taken_cnt), 32'hFFFF);
    check("sat_redirect", 32'(redirect), 32'd1);
    check("sat_stcnt", 32'(stall_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
